// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-atomic arbiter that shares one uart_tx among N_REQ byte-stream requesters.
// Optional stall abort with timeout_err pulse is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int N_REQ = 2
`ifdef UART_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 4096
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   grant,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  input  logic               tx_busy,
  output logic               timeout_err,
  output logic [1:0]         state_dbg
);

  localparam int IDX_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT_HI = 2'd2,
    S_WAIT_LO = 2'd3
  } state_t;

  state_t             state, state_nx;
  logic [N_REQ-1:0]   grant_nx;
  logic [IDX_W-1:0]   g_idx, g_idx_nx;
  logic [IDX_W-1:0]   rr_ptr, rr_nx;
  logic               tx_start_nx;
  logic [7:0]         tx_data_nx;
  logic               last_q, last_nx;

  logic               pick_any;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W:0]     cand;

  logic               cur_valid;
  logic [7:0]         cur_data;
  logic               cur_last;
  logic               xfer;

  assign state_dbg = state;

  // Round-robin search starting just after the last owner, wrapping at N_REQ.
  always_comb begin
    pick_any = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N_REQ)) cand = cand - (IDX_W+1)'(N_REQ);
      if (!pick_any && req_valid[cand[IDX_W-1:0]]) begin
        pick_any = 1'b1;
        pick_idx = cand[IDX_W-1:0];
      end
    end
  end

  assign cur_valid = req_valid[g_idx];
  assign cur_data  = req_data[{g_idx, 3'b000} +: 8];
  assign cur_last  = req_last[g_idx];

  // Handshake: a byte moves when req_valid[i] & req_ready[i] are both high at a rising clk edge.
  // Only the granted requester can see ready, only in ISSUE, and only while the UART is idle.
  assign req_ready = grant & {N_REQ{(state == S_ISSUE) & ~tx_busy}};
  assign xfer      = (state == S_ISSUE) & ~tx_busy & cur_valid;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  logic [CNT_W-1:0] stall_cnt;
  logic             timeout_nx;
`endif

  always_comb begin
    state_nx    = state;
    grant_nx    = grant;
    g_idx_nx    = g_idx;
    rr_nx       = rr_ptr;
    tx_start_nx = 1'b0;
    tx_data_nx  = tx_data;
    last_nx     = last_q;
`ifdef UART_ARB_TIMEOUT_EN
    timeout_nx  = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (pick_any) begin
          grant_nx           = '0;
          grant_nx[pick_idx] = 1'b1;
          g_idx_nx           = pick_idx;
          state_nx           = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (xfer) begin
          tx_data_nx  = cur_data;
          last_nx     = cur_last;
          tx_start_nx = 1'b1;
          state_nx    = S_WAIT_HI;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (stall_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          grant_nx   = '0;
          rr_nx      = g_idx;
          timeout_nx = 1'b1;
          state_nx   = S_IDLE;
        end
`endif
      end
      S_WAIT_HI: begin
        if (tx_busy) state_nx = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (!tx_busy) begin
          if (last_q) begin
            rr_nx    = g_idx;
            grant_nx = '0;
            state_nx = S_IDLE;
          end else begin
            state_nx = S_ISSUE;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      grant    <= '0;
      g_idx    <= '0;
      rr_ptr   <= IDX_W'(N_REQ - 1);
      tx_start <= 1'b0;
      tx_data  <= '0;
      last_q   <= 1'b0;
    end else begin
      state    <= state_nx;
      grant    <= grant_nx;
      g_idx    <= g_idx_nx;
      rr_ptr   <= rr_nx;
      tx_start <= tx_start_nx;
      tx_data  <= tx_data_nx;
      last_q   <= last_nx;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  // Counter sits at zero outside ISSUE, so it always starts fresh on entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= timeout_nx;
      if (state != S_ISSUE) stall_cnt <= '0;
      else if (!xfer)       stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural uart_tx (1 MHz clk, 9600 baud), line decoder and byte scoreboard.
// Defining UART_ARB_TIMEOUT_EN adds the stall-abort scenario with TIMEOUT_CYC=16.
module tb_uart_tx_arbiter;

  localparam int BIT_CYC = 1_000_000 / 9600;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic [1:0]  grant;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        timeout_err;
  logic [1:0]  state_dbg;

  int checks   = 0;
  int failures = 0;
  int to_pulses = 0;

  logic [9:0] exp_q[$];   // {requester index, byte}
  logic [1:0] gnt_q[$];   // grant seen at each tx_start
  logic [8:0] rq0[$];     // {last, byte}
  logic [8:0] rq1[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial rst = 1'b1;

  uart_tx_arbiter #(
    .N_REQ(2)
`ifdef UART_ARB_TIMEOUT_EN
    , .TIMEOUT_CYC(16)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .grant(grant), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  // behavioural uart_tx: busy rises the cycle after tx_start, frame = start, 8 data LSB first, stop
  logic       u_busy, u_line;
  logic [9:0] u_shift;
  int         u_bit, u_cnt;
  assign tx_busy = u_busy;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      u_busy <= 1'b0; u_line <= 1'b1; u_shift <= '1; u_bit <= 0; u_cnt <= 0;
    end else if (!u_busy) begin
      if (tx_start) begin
        u_busy <= 1'b1; u_shift <= {1'b1, tx_data, 1'b0}; u_line <= 1'b0; u_bit <= 0; u_cnt <= 0;
      end
    end else if (u_cnt == BIT_CYC - 1) begin
      u_cnt <= 0;
      if (u_bit == 9) begin
        u_busy <= 1'b0; u_line <= 1'b1;
      end else begin
        u_bit <= u_bit + 1; u_line <= u_shift[u_bit + 1];
      end
    end else begin
      u_cnt <= u_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // driver: requesters present the head of their queue, pop on an accepted transfer
  initial begin : driver
    logic [1:0] xfer;
    req_valid = '0; req_data = '0; req_last = '0;
    forever begin
      @(negedge clk);
      xfer = req_valid & req_ready;
      @(posedge clk);
      #1;
      if (rst) xfer = '0;
      if (xfer[0] && rq0.size() != 0) void'(rq0.pop_front());
      if (xfer[1] && rq1.size() != 0) void'(rq1.pop_front());
      req_valid[0] = (rq0.size() != 0);
      req_valid[1] = (rq1.size() != 0);
      if (rq0.size() != 0) {req_last[0], req_data[7:0]}  = rq0[0];
      if (rq1.size() != 0) {req_last[1], req_data[15:8]} = rq1[0];
    end
  end

  // per-cycle protocol monitor
  initial begin : proto_mon
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("ready_outside_grant", req_ready & ~grant, 0);
        check("grant_onehot0", $onehot0(grant), 1);
        if (tx_start) begin
          check("tx_start_overlap", u_busy, 0);
          gnt_q.push_back(grant);
        end
        if (u_busy) check("tx_data_hold", tx_data, u_shift[8:1]);
        if (timeout_err) begin
          to_pulses++;
          check("timeout_grant", grant, 0);
        end
      end
    end
  end

  task automatic rx_wait(input int n, output bit ab);
    ab = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rst) begin ab = 1'b1; return; end
    end
  endtask

  // line decoder + scoreboard pop
  initial begin : decoder
    logic [7:0] rx;
    logic [9:0] e;
    logic [1:0] g;
    bit ab;
    rx = '0;
    forever begin
      @(negedge clk);
      if (!rst && u_line == 1'b0) begin
        rx_wait(BIT_CYC / 2, ab);
        for (int b = 0; b < 8; b++) begin
          if (!ab) begin
            rx_wait(BIT_CYC, ab);
            rx[b] = u_line;
          end
        end
        if (!ab) rx_wait(BIT_CYC, ab);
        if (ab) begin
          if (gnt_q.size() != 0) void'(gnt_q.pop_front());
        end else begin
          check("stop_bit", u_line, 1);
          g = 2'b00;
          if (gnt_q.size() != 0) g = gnt_q.pop_front();
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_byte actual=%02h required=none", rx);
          end else begin
            e = exp_q.pop_front();
            check("line_byte", rx, e[7:0]);
            check("byte_grant", g, 2'b01 << e[8]);
          end
        end
      end
    end
  end

  task automatic check_reset(input string name);
    check({name, "_grant"}, grant, 0);
    check({name, "_tx_start"}, tx_start, 0);
    check({name, "_tx_data"}, tx_data, 0);
    check({name, "_req_ready"}, req_ready, 0);
    check({name, "_timeout_err"}, timeout_err, 0);
    check({name, "_state"}, state_dbg, 0);
  endtask

  task automatic enter_reset();
    @(negedge clk);
    rst = 1'b1;
    rq0.delete();
    rq1.delete();
  endtask

  task automatic leave_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic expect_byte(input logic idx, input logic [7:0] b);
    exp_q.push_back({1'b0, idx, b});
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || grant != 0 || u_busy) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain_in_time"}, (n < 20000), 1);
    if (n >= 20000) exp_q.delete();
    check({name, "_grant_idle"}, grant, 0);
    check({name, "_state_idle"}, state_dbg, 0);
  endtask

  task automatic wait_starts(input string name, input int cnt);
    int seen, n;
    seen = 0; n = 0;
    while (seen < cnt && n < 5000) begin
      @(negedge clk);
      if (tx_start) seen++;
      n++;
    end
    check(name, seen, cnt);
  endtask

  initial begin : watchdog
    #900000;
    failures++;
    $display("FAIL watchdog actual=timeout required=completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : stimulus
    int n;
    repeat (2) @(negedge clk);
    #1;
    check_reset("por");

    // single packet from req0: 12 34 56
    rq0.push_back({1'b0, 8'h12}); rq0.push_back({1'b0, 8'h34}); rq0.push_back({1'b1, 8'h56});
    expect_byte(1'b0, 8'h12); expect_byte(1'b0, 8'h34); expect_byte(1'b0, 8'h56);
    leave_reset();
    drain("pkt3");

    // both valid from reset: req0 first, then req1
    enter_reset();
    rq0.push_back({1'b1, 8'hA5}); rq1.push_back({1'b1, 8'h3C});
    expect_byte(1'b0, 8'hA5); expect_byte(1'b1, 8'h3C);
    leave_reset();
    drain("both");

    // req0 streams single-byte packets, req1 must get a turn after the first
    enter_reset();
    rq0.push_back({1'b1, 8'h01}); rq0.push_back({1'b1, 8'h02});
    rq0.push_back({1'b1, 8'h03}); rq0.push_back({1'b1, 8'h04});
    rq1.push_back({1'b1, 8'h77});
    expect_byte(1'b0, 8'h01); expect_byte(1'b1, 8'h77); expect_byte(1'b0, 8'h02);
    expect_byte(1'b0, 8'h03); expect_byte(1'b0, 8'h04);
    leave_reset();
    drain("stream");

    // req1 arrives during a 4-byte req0 packet and waits for the whole packet
    enter_reset();
    rq0.push_back({1'b0, 8'h11}); rq0.push_back({1'b0, 8'h22});
    rq0.push_back({1'b0, 8'h33}); rq0.push_back({1'b1, 8'h44});
    expect_byte(1'b0, 8'h11); expect_byte(1'b0, 8'h22); expect_byte(1'b0, 8'h33);
    expect_byte(1'b0, 8'h44); expect_byte(1'b1, 8'h5B);
    leave_reset();
    wait_starts("midpkt_first_start", 1);
    rq1.push_back({1'b1, 8'h5B});
    drain("midpkt");

    // reset during WAIT_LO of byte 2, then req0 priority restored
    enter_reset();
    rq0.push_back({1'b0, 8'hC1}); rq0.push_back({1'b0, 8'hC2}); rq0.push_back({1'b1, 8'hC3});
    expect_byte(1'b0, 8'hC1);
    leave_reset();
    wait_starts("rstmid_two_starts", 2);
    n = 0;
    while (state_dbg != 2'd3 && n < 100) begin @(negedge clk); n++; end
    check("rstmid_in_wait_lo", state_dbg, 3);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset("rstmid");
    rq0.delete(); rq1.delete();
    rq0.push_back({1'b1, 8'hF0}); rq1.push_back({1'b1, 8'hE1});
    expect_byte(1'b0, 8'hF0); expect_byte(1'b1, 8'hE1);
    leave_reset();
    drain("after_rst");

`ifdef UART_ARB_TIMEOUT_EN
    // req0 sends a non-last byte then goes quiet; stall abort hands the UART to req1
    enter_reset();
    rq0.push_back({1'b0, 8'h01}); rq1.push_back({1'b1, 8'h99});
    expect_byte(1'b0, 8'h01); expect_byte(1'b1, 8'h99);
    leave_reset();
    drain("timeout");
    check("timeout_pulses", to_pulses, 1);
`else
    check("timeout_never", to_pulses, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
